pdp_mem_responder: RTL

- Word-addressed memory responder serving the accumulator CPU's multicycle memory interface. This is the target side of the MemRead/MemWrite/address/write-data requests the datapath issues.
- Stalls the requester through a configurable access latency and returns a one-cycle ready pulse.
- For reads, it also presents read data.
- Sits beside the CPU top in the system and replaces the ideal zero-wait memory for latency-tolerant testing.

---
 rtl/pdp_mem_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pdp_mem_responder.sv
// pdp_mem_responder
// -----------------
// Word-addressed memory target for the accumulator CPU's multicycle memory
// interface. A request (MemRead or MemWrite) is accepted only in IDLE. The
// responder then stalls for a per-operation latency and finishes with a
// single-cycle mem_ready pulse. For reads, rdata carries the word during that
// pulse and keeps it until the next read completes.
//
// Handshake: a request is a level on MemRead/MemWrite, sampled only while
// IDLE. The rising edge that samples it is the acceptance edge. mem_ready is
// high for exactly one cycle, RD_LAT/WR_LAT cycles after acceptance. The
// requester must drop its request in the cycle after mem_ready. A request
// still high when the block is back in IDLE starts a new access.
//
// Parameters:
//   ADDR_W  address width in bits
//   DATA_W  data word width in bits
//   DEPTH   number of words (power of two, <= 2**ADDR_W); addr wraps modulo DEPTH
//   RD_LAT  cycles from read acceptance to mem_ready (1..15)
//   WR_LAT  cycles from write acceptance to mem_ready (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   MemRead    read request level
//   MemWrite   write request level
//   addr       word address
//   wdata      write data
//   rdata      read data, valid while mem_ready=1 for a read
//   mem_ready  one-cycle completion pulse
//   busy       high from the cycle after acceptance through the ready cycle
//   req_err    one-cycle pulse after MemRead and MemWrite were both high in IDLE
//   state_dbg  current FSM state (0=IDLE, 1=WAIT, 2=DONE)
//   rd_count   completed reads, 16-bit wrapping (PDP_MEM_ACCESS_CNT_EN only)
//   wr_count   completed writes, 16-bit wrapping (PDP_MEM_ACCESS_CNT_EN only)
//
// Optional feature macro: PDP_MEM_ACCESS_CNT_EN adds rd_count/wr_count.

module pdp_mem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              req_err,
  output logic [1:0]        state_dbg
`ifdef PDP_MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Counter preload: the WAIT state lasts LAT-1 cycles, DONE is the LAT-th.
  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);
  localparam logic       RD_ONE = (RD_LAT == 1);
  localparam logic       WR_ONE = (WR_LAT == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [AW-1:0]     lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  // Request decode
  logic req_rd;
  logic req_wr;
  logic req_any;
  logic req_both;
  logic lat_one;

  assign req_rd   = MemRead & ~MemWrite;
  assign req_wr   = MemWrite & ~MemRead;
  assign req_any  = req_rd | req_wr;
  assign req_both = MemRead & MemWrite;
  assign lat_one  = req_wr ? WR_ONE : RD_ONE;

  // Upper address bits are deliberately dropped so the address wraps.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Access strobe: asserted on the edge that enters DONE. With a latency of
  // one, that edge is the acceptance edge itself, so the live inputs are used
  // because nothing has been latched yet. Otherwise the latched copies are used.
  logic              acc_go;
  logic              acc_wr;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_comb begin
    acc_go    = 1'b0;
    acc_wr    = op_wr;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    case (state)
      IDLE: begin
        if (req_any && lat_one) begin
          acc_go    = 1'b1;
          acc_wr    = req_wr;
          acc_addr  = addr[AW-1:0];
          acc_wdata = wdata;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) acc_go = 1'b1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      req_err   <= 1'b0;
`ifdef PDP_MEM_ACCESS_CNT_EN
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
`endif
    end else begin
      mem_ready <= 1'b0;
      req_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            op_wr     <= req_wr;
            lat_addr  <= addr[AW-1:0];
            lat_wdata <= wdata;
            cnt       <= req_wr ? WR_CNT : RD_CNT;
            busy      <= 1'b1;
            if (lat_one) begin
              state     <= DONE;
              mem_ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (req_both) begin
            // Conflicting request: flag it, perform no access.
            req_err <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= DONE;
            mem_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef PDP_MEM_ACCESS_CNT_EN
          if (op_wr) wr_count <= wr_count + 16'd1;
          else       rd_count <= rd_count + 16'd1;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (acc_go && !acc_wr) rdata <= mem[acc_addr];
    end
  end

  // Storage array, never reset. A write lands on the edge entering DONE, so
  // a reset before that edge leaves the word untouched.
  always_ff @(posedge clk) begin
    if (rst && acc_go && acc_wr) mem[acc_addr] <= acc_wdata;
  end

  assign state_dbg = state;

endmodule
